// File: rtl/pq_sieve.sv
// Trial-divides FIFO candidates by odd primes 3..23 bit-serially and forwards survivors on valid/ready.
// Latency rd_en->valid NUM_BITS+3 cycles; no FIFO read while a survivor waits for ready.
module pq_sieve #(
   parameter int NUM_BITS  = 128,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   output logic                 pq_fifo_rd_en,
   input  logic [NUM_BITS-1:0]  pq_fifo_dout,
   input  logic                 pq_fifo_empty,
   output logic [NUM_BITS-1:0]  m_cand_data,
   output logic                 m_cand_valid,
   input  logic                 m_cand_ready,
   output logic [CNT_WIDTH-1:0] cnt_accepted,
   output logic [CNT_WIDTH-1:0] cnt_rejected,
   output logic                 busy
);

   localparam int NP = 8;
   localparam int BW = $clog2(NUM_BITS);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SIEVE, DECIDE, OUTPUT} state_t;

   function automatic logic [4:0] prime(input int i);
      case (i)
         0: prime = 5'd3;
         1: prime = 5'd5;
         2: prime = 5'd7;
         3: prime = 5'd11;
         4: prime = 5'd13;
         5: prime = 5'd17;
         6: prime = 5'd19;
         default: prime = 5'd23;
      endcase
   endfunction

   state_t              state, state_n;
   logic [NUM_BITS-1:0] cand;
   logic [4:0]          r     [NP];
   logic [4:0]          r_nxt [NP];
   logic [BW-1:0]       bit_idx;
   logic                accept;

   // Shift in one candidate bit per cycle; t < 2*P so one subtract reduces it.
   always_comb begin
      logic [5:0] t;
      t = '0;
      for (int i = 0; i < NP; i++) begin
         t = {r[i], cand[bit_idx]};
         if (t >= {1'b0, prime(i)})
            t = t - {1'b0, prime(i)};
         r_nxt[i] = t[4:0];
      end
   end

   // A zero residue only disqualifies when the candidate is not the table prime itself.
   always_comb begin
      accept = 1'b1;
      if (cand < NUM_BITS'(2))
         accept = 1'b0;
      if (!cand[0] && cand != NUM_BITS'(2))
         accept = 1'b0;
      for (int i = 0; i < NP; i++) begin
         if (r[i] == 5'd0 && cand != NUM_BITS'(prime(i)))
            accept = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (!pq_fifo_empty) state_n = FETCH;
         FETCH:   state_n = CAPTURE;
         CAPTURE: state_n = SIEVE;
         SIEVE:   if (bit_idx == '0) state_n = DECIDE;
         DECIDE:  state_n = accept ? OUTPUT : IDLE;
         OUTPUT:  if (m_cand_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pq_fifo_rd_en <= 1'b0;
         cand          <= '0;
         bit_idx       <= '0;
         m_cand_data   <= '0;
         m_cand_valid  <= 1'b0;
         cnt_accepted  <= '0;
         cnt_rejected  <= '0;
         for (int i = 0; i < NP; i++)
            r[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!pq_fifo_empty)
                  pq_fifo_rd_en <= 1'b1;
            end
            FETCH: pq_fifo_rd_en <= 1'b0;
            CAPTURE: begin
               cand    <= pq_fifo_dout;
               bit_idx <= BW'(NUM_BITS - 1);
               for (int i = 0; i < NP; i++)
                  r[i] <= '0;
            end
            SIEVE: begin
               bit_idx <= bit_idx - 1'b1;
               for (int i = 0; i < NP; i++)
                  r[i] <= r_nxt[i];
            end
            DECIDE: begin
               if (accept) begin
                  m_cand_data  <= cand;
                  m_cand_valid <= 1'b1;
                  if (cnt_accepted != CNT_MAX)
                     cnt_accepted <= cnt_accepted + 1'b1;
               end else if (cnt_rejected != CNT_MAX) begin
                  cnt_rejected <= cnt_rejected + 1'b1;
               end
            end
            OUTPUT: begin
               if (m_cand_ready)
                  m_cand_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pq_sieve.sv
// Directed bench for pq_sieve: behavioural FIFO, handshake monitor, hand-computed expectations.
module tb_pq_sieve;
   localparam int NB = 128;
   localparam int CW = 32;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          pq_fifo_rd_en;
   logic [NB-1:0] pq_fifo_dout = '0;
   logic          pq_fifo_empty = 1'b1;
   logic [NB-1:0] m_cand_data;
   logic          m_cand_valid;
   logic          m_cand_ready = 1'b1;
   logic [CW-1:0] cnt_accepted;
   logic [CW-1:0] cnt_rejected;
   logic          busy;

   pq_sieve #(.NUM_BITS(NB), .CNT_WIDTH(CW)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .pq_fifo_rd_en (pq_fifo_rd_en),
      .pq_fifo_dout  (pq_fifo_dout),
      .pq_fifo_empty (pq_fifo_empty),
      .m_cand_data   (m_cand_data),
      .m_cand_valid  (m_cand_valid),
      .m_cand_ready  (m_cand_ready),
      .cnt_accepted  (cnt_accepted),
      .cnt_rejected  (cnt_rejected),
      .busy          (busy)
   );

   always #5 aclk = ~aclk;

   logic [NB-1:0] fifo_q [$];
   logic [NB-1:0] acc_q  [$];
   int cyc = 0, rd_pulses = 0, rd_cyc = 0, vrise_cyc = 0, v_rises = 0;
   logic vprev = 1'b0;
   int n_chk = 0, n_fail = 0;

   // Show-ahead-free FIFO: data appears the cycle after the read strobe.
   always @(posedge aclk) begin
      if (pq_fifo_rd_en && fifo_q.size() > 0)
         pq_fifo_dout <= fifo_q.pop_front();
   end

   always @(negedge aclk)
      pq_fifo_empty = (fifo_q.size() == 0);

   always @(posedge aclk) begin
      cyc <= cyc + 1;
      if (pq_fifo_rd_en) begin
         rd_pulses <= rd_pulses + 1;
         rd_cyc    <= cyc;
      end
      if (m_cand_valid && !vprev) begin
         vrise_cyc <= cyc;
         v_rises   <= v_rises + 1;
      end
      vprev <= m_cand_valid;
      if (m_cand_valid && m_cand_ready)
         acc_q.push_back(m_cand_data);
   end

   task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int total, input string tag);
      int k;
      k = 0;
      while (!((cnt_accepted + cnt_rejected) >= CW'(total) && !busy && !m_cand_valid
               && fifo_q.size() == 0) && k < 3000) begin
         @(negedge aclk);
         k++;
      end
      if (k >= 3000) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: timeout, processed %0d expected %0d", tag,
                  cnt_accepted + cnt_rejected, total);
      end
   endtask

   initial begin
      logic [NB-1:0] mers;
      int rd0, v0, bad, k;
      mers = {1'b0, {127{1'b1}}};

      // Reset state
      repeat (3) @(negedge aclk);
      check("rst_rd_en", pq_fifo_rd_en, 0);
      check("rst_valid", m_cand_valid, 0);
      check("rst_data", m_cand_data, 0);
      check("rst_acc", cnt_accepted, 0);
      check("rst_rej", cnt_rejected, 0);
      check("rst_busy", busy, 0);
      aresetn = 1'b1;
      repeat (2) @(negedge aclk);

      // 15 = 3*5 is rejected with a single read and no valid
      rd0 = rd_pulses; v0 = v_rises;
      fifo_q.push_back(NB'(15));
      wait_done(1, "c15");
      check("c15_rej", cnt_rejected, 1);
      check("c15_acc", cnt_accepted, 0);
      check("c15_novalid", v_rises - v0, 0);
      check("c15_rd_pulses", rd_pulses - rd0, 1);

      // 29 accepted with fixed latency
      fifo_q.push_back(NB'(29));
      wait_done(2, "c29");
      check("c29_latency", vrise_cyc - rd_cyc, 131);
      check("c29_data", acc_q[acc_q.size()-1], 29);
      check("c29_acc", cnt_accepted, 1);

      // Mersenne prime accepted, 3*65537 rejected
      fifo_q.push_back(mers);
      fifo_q.push_back(NB'(196611));
      wait_done(4, "mers");
      check("mers_data", acc_q[acc_q.size()-1], mers);
      check("mers_acc", cnt_accepted, 2);
      check("mers_rej", cnt_rejected, 2);

      // Boundary values: table prime, 2, 1, even
      fifo_q.push_back(NB'(23));
      fifo_q.push_back(NB'(2));
      fifo_q.push_back(NB'(1));
      fifo_q.push_back(NB'(256));
      wait_done(8, "edge");
      check("edge_first", acc_q[acc_q.size()-2], 23);
      check("edge_second", acc_q[acc_q.size()-1], 2);
      check("edge_acc", cnt_accepted, 4);
      check("edge_rej", cnt_rejected, 4);

      // Backpressure: survivor held, no reads while stalled
      m_cand_ready = 1'b0;
      fifo_q.push_back(NB'(65537));
      fifo_q.push_back(NB'(29));
      k = 0;
      while (!m_cand_valid && k < 500) begin
         @(negedge aclk);
         k++;
      end
      check("bp_valid_rise", m_cand_valid, 1);
      rd0 = rd_pulses; bad = 0;
      repeat (20) begin
         @(negedge aclk);
         if (m_cand_valid !== 1'b1 || m_cand_data !== NB'(65537))
            bad++;
      end
      check("bp_stable", bad, 0);
      check("bp_no_rd", rd_pulses - rd0, 0);
      check("bp_empty_low", pq_fifo_empty, 0);
      m_cand_ready = 1'b1;
      @(negedge aclk);
      check("bp_valid_drop", m_cand_valid, 0);
      check("bp_rd_wait", pq_fifo_rd_en, 0);
      @(negedge aclk);
      check("bp_rd_restart", pq_fifo_rd_en, 1);
      wait_done(10, "bp");
      check("bp_held_data", acc_q[acc_q.size()-2], 65537);
      check("bp_next_data", acc_q[acc_q.size()-1], 29);
      check("bp_acc", cnt_accepted, 6);

      // Asynchronous reset in the middle of the sieve
      fifo_q.push_back(NB'(74565));
      k = 0;
      while (k < 50) begin
         @(posedge aclk);
         #1;
         if (pq_fifo_rd_en) break;
         k++;
      end
      repeat (69) @(posedge aclk);
      #1;
      check("mid_busy", busy, 1);
      #2 aresetn = 1'b0;
      #1;
      check("mid_rd_en", pq_fifo_rd_en, 0);
      check("mid_valid", m_cand_valid, 0);
      check("mid_data", m_cand_data, 0);
      check("mid_acc", cnt_accepted, 0);
      check("mid_rej", cnt_rejected, 0);
      check("mid_busy_clr", busy, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      fifo_q.push_back(NB'(31));
      wait_done(1, "post_rst");
      check("post_rst_data", acc_q[acc_q.size()-1], 31);
      check("post_rst_acc", cnt_accepted, 1);
      check("post_rst_rej", cnt_rejected, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
